// File: rtl/tinker_pkg.sv
// Shared widths, reset PC and the fetch-queue entry layout for the tinker_core front end.
package tinker_pkg;
  localparam int INST_W = 32;
  localparam int ADDR_W = 64;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 64'h2000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fq_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/tinker_sync_fifo.sv
// Synchronous FIFO with clear; head is read straight from the storage registers (no bypass).
module tinker_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  // A full queue may still accept a push when the head leaves in the same cycle.
  assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data  = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign count      = count_q;
endmodule

// File: rtl/tinker_fetch_queue.sv
// Instruction fetch front end: issues word reads, queues {pc, inst} for decode, and
// flushes on redirect while dropping responses that belong to the old fetch stream.
module tinker_fetch_queue
  import tinker_pkg::*;
#(
  parameter int                DEPTH           = 4,
  parameter int                MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] RESET_PC        = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              flushed
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = CW + OW;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [OW-1:0]     outstanding_q, outstanding_d, discard_q, discard_d;
  logic              flushed_q;
  logic [CW-1:0]     fifo_count;
  logic              issue, resp, keep, pop, head_valid;
  fq_entry_t         push_entry, head_entry;

  // Every slot already promised to an in-flight read counts against the queue depth.
  assign imem_req = !reset && !redirect_valid
                 && ((SW'(fifo_count) + SW'(outstanding_q)) < SW'(DEPTH))
                 && (outstanding_q < OW'(MAX_OUTSTANDING));
  assign issue    = imem_req && imem_ready;
  assign resp     = imem_rvalid && (outstanding_q != '0);
  assign keep     = resp && (discard_q == '0) && !redirect_valid;
  assign pop      = head_valid && inst_ready;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + OW'(issue) - OW'(resp);
    discard_d     = discard_q;
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      resp_pc_d  = word_align(redirect_pc);
      // Discards are a subset of outstanding reads, so after a flush every read still
      // in flight is stale; this also keeps back-to-back redirects from double counting.
      discard_d  = outstanding_q - OW'(resp);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + 64'd4;
      if (keep)  resp_pc_d  = resp_pc_q + 64'd4;
      if (resp && (discard_q != '0)) discard_d = discard_q - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      flushed_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      flushed_q     <= redirect_valid;
    end
  end

  assign push_entry.pc   = resp_pc_q;
  assign push_entry.inst = imem_rdata;

  tinker_sync_fifo #(
    .WIDTH ($bits(fq_entry_t)),
    .DEPTH (DEPTH)
  ) fetch_fifo (
    .clk        (clk),
    .reset      (reset),
    .clear      (redirect_valid),
    .push       (keep),
    .push_data  (push_entry),
    .pop        (pop),
    .head_data  (head_entry),
    .head_valid (head_valid),
    .count      (fifo_count)
  );

  assign imem_addr  = fetch_pc_q;
  assign inst_valid = head_valid;
  assign inst_data  = head_entry.inst;
  assign inst_pc    = head_entry.pc;
  assign flushed    = flushed_q;
endmodule

// File: tb/tb_tinker_fetch_queue.sv
// Bench for tinker_fetch_queue: in-order memory returning data = addr[31:0], a stream
// model of the delivered pcs, and directed scenarios with literal expectations.
module tb_tinker_fetch_queue;
  import tinker_pkg::*;

  logic        clk = 1'b0;
  logic        reset, redirect_valid, imem_req, imem_ready, imem_rvalid;
  logic        inst_valid, inst_ready, flushed;
  logic [63:0] redirect_pc, imem_addr, inst_pc;
  logic [31:0] imem_rdata, inst_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tinker_fetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .flushed        (flushed)
  );

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] due;
  } rd_t;

  bit          ready_on, ready_toggle, hold, stray, resp_now;
  int          lat = 1;
  int          cyc = 0;
  rd_t         mem_q[$];
  rd_t         new_rd;
  logic [63:0] acc_q[$], pop_q[$];
  logic [31:0] popd_q[$];
  logic [63:0] exp_pc = 64'h2000;
  logic [63:0] exp_fetch = 64'h2000;
  logic [63:0] held_pc;
  bit          prev_redir, hold_prev;
  int          fl_cnt = 0;
  int          acc_cyc = 0;
  int          iv_cyc = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] at(input logic [63:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 64'hffff_ffff_ffff_ffff;
  endfunction

  // Memory: responds in order, lat cycles after accept, unless held.
  initial begin
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      imem_ready  = ready_toggle ? cyc[0] : ready_on;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      resp_now    = 1'b0;
      if (stray) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hdead_beef;
      end else if (!hold && mem_q.size() > 0 && int'(mem_q[0].due) <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_q[0].addr[31:0];
        void'(mem_q.pop_front());
        resp_now    = 1'b1;
      end
    end
  end

  // Model: decode sees a gap-free pc stream starting at the last restart point.
  always @(negedge clk) begin
    chk("flushed", flushed, prev_redir);
    if (inst_valid && inst_ready) begin
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst_data", inst_data, exp_pc[31:0]);
      pop_q.push_back(inst_pc);
      popd_q.push_back(inst_data);
      exp_pc = exp_pc + 64'd4;
    end
    if (hold_prev) begin
      chk("head_hold_valid", inst_valid, 1);
      chk("head_hold_pc", inst_pc, held_pc);
    end
    if (reset || redirect_valid) chk("req_blocked", imem_req, 0);
    if (mem_q.size() + int'(resp_now) >= 2) chk("req_max_out", imem_req, 0);
    if (imem_req && imem_ready) begin
      chk("imem_addr", imem_addr, exp_fetch);
      if (acc_q.size() == 0) acc_cyc = cyc;
      acc_q.push_back(imem_addr);
      new_rd.addr = imem_addr;
      new_rd.due  = cyc + lat;
      mem_q.push_back(new_rd);
      exp_fetch = exp_fetch + 64'd4;
    end
    if (inst_valid && iv_cyc < 0) iv_cyc = cyc;
    if (flushed) fl_cnt++;
    hold_prev  = inst_valid && !inst_ready && !reset && !redirect_valid;
    held_pc    = inst_pc;
    prev_redir = redirect_valid && !reset;
    if (reset) begin
      exp_pc    = 64'h2000;
      exp_fetch = 64'h2000;
      mem_q.delete();
    end else if (redirect_valid) begin
      exp_pc    = {redirect_pc[63:2], 2'b00};
      exp_fetch = {redirect_pc[63:2], 2'b00};
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    acc_q.delete();
    pop_q.delete();
    popd_q.delete();
    iv_cyc = -1;
    fl_cnt = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; redirect_valid = 1'b0; inst_ready = 1'b0;
    ready_on = 0; ready_toggle = 0; hold = 0; stray = 0;
    tick(n);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_flushed", flushed, 0);
    chk("rst_addr", imem_addr, 64'h2000);
    clear_logs();
    reset = 1'b0;
  endtask

  initial begin
    int n4000;
    int nacc;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

    // Startup streaming
    do_reset(2);
    lat = 1; ready_on = 1; inst_ready = 1;
    tick(12);
    chk("t1_acc0", at(acc_q, 0), 64'h2000);
    chk("t1_acc1", at(acc_q, 1), 64'h2004);
    chk("t1_acc2", at(acc_q, 2), 64'h2008);
    chk("t1_pop0", at(pop_q, 0), 64'h2000);
    chk("t1_data0", (popd_q.size() > 0) ? popd_q[0] : 32'hffff_ffff, 32'h0000_2000);
    chk("t1_iv_lat", iv_cyc - acc_cyc, 2);
    chk("t1_pops", pop_q.size() >= 8, 1);

    // Backpressure
    do_reset(2);
    lat = 1; ready_on = 1; inst_ready = 0;
    tick(10);
    chk("t2_acc_n", acc_q.size(), 4);
    chk("t2_req_off", imem_req, 0);
    chk("t2_valid", inst_valid, 1);
    chk("t2_head", inst_pc, 64'h2000);
    inst_ready = 1; tick(1); inst_ready = 0;
    tick(6);
    chk("t2_acc_n2", acc_q.size(), 5);
    chk("t2_acc4", at(acc_q, 4), 64'h2010);
    chk("t2_pop_n", pop_q.size(), 1);
    chk("t2_head2", inst_pc, 64'h2004);
    chk("t2_req_off2", imem_req, 0);

    // Flush with two reads in flight
    do_reset(2);
    lat = 1; inst_ready = 1; ready_on = 1;
    tick(2); ready_on = 0; tick(3);
    hold = 1; ready_on = 1; tick(2); ready_on = 0;
    chk("t3_acc_n", acc_q.size(), 4);
    chk("t3_acc3", at(acc_q, 3), 64'h200c);
    redirect_valid = 1; redirect_pc = 64'h3001;
    tick(1);
    redirect_valid = 0; hold = 0; ready_on = 1;
    chk("t3_flushed", flushed, 1);
    chk("t3_iv_off", inst_valid, 0);
    tick(12);
    chk("t3_acc4", at(acc_q, 4), 64'h3000);
    chk("t3_pop1", at(pop_q, 1), 64'h2004);
    chk("t3_pop2", at(pop_q, 2), 64'h3000);
    chk("t3_fl_cnt", fl_cnt, 1);

    // Redirect together with a response and a pop
    do_reset(2);
    lat = 1; inst_ready = 0; ready_on = 1;
    tick(1); ready_on = 0; tick(3);
    chk("t4_head", inst_pc, 64'h2000);
    hold = 1; ready_on = 1; tick(2); ready_on = 0;
    chk("t4_acc_n", acc_q.size(), 3);
    hold = 0; inst_ready = 1; redirect_valid = 1; redirect_pc = 64'h6000;
    tick(1);
    redirect_valid = 0; ready_on = 1;
    chk("t4_iv_off", inst_valid, 0);
    chk("t4_pop_n", pop_q.size(), 1);
    tick(12);
    chk("t4_pop0", at(pop_q, 0), 64'h2000);
    chk("t4_pop1", at(pop_q, 1), 64'h6000);
    chk("t4_acc3", at(acc_q, 3), 64'h6000);

    // Back-to-back redirects with slow memory
    do_reset(2);
    lat = 2; ready_toggle = 1; inst_ready = 1;
    tick(7);
    inst_ready = 0; redirect_valid = 1; redirect_pc = 64'h4000;
    tick(1);
    redirect_pc = 64'h5000;
    tick(1);
    redirect_valid = 0; inst_ready = 1;
    pop_q.delete();
    nacc = acc_q.size();
    tick(40);
    n4000 = 0;
    foreach (pop_q[i]) if (pop_q[i] == 64'h4000) n4000++;
    chk("t5_no_4000", n4000, 0);
    chk("t5_pop0", at(pop_q, 0), 64'h5000);
    chk("t5_pop1", at(pop_q, 1), 64'h5004);
    chk("t5_pop_n", pop_q.size() >= 4, 1);
    chk("t5_acc_first", at(acc_q, nacc), 64'h5000);

    // Reset mid-operation with stray responses
    do_reset(2);
    lat = 1; ready_on = 1; inst_ready = 0;
    tick(3); hold = 1; tick(1);
    chk("t6_pre_valid", inst_valid, 1);
    chk("t6_pre_acc", acc_q.size(), 4);
    reset = 1; hold = 0; ready_on = 0; stray = 1;
    tick(2);
    reset = 0;
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("t6_no_push", inst_valid, 0);
    end
    chk("t6_addr", imem_addr, 64'h2000);
    stray = 0; ready_on = 1; inst_ready = 1;
    tick(8);
    chk("t6_acc0", at(acc_q, 0), 64'h2000);
    chk("t6_pop0", at(pop_q, 0), 64'h2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
